// File: rtl/mbt_pkg.sv
// mbt_pkg: shared defaults, escape threshold and FSM encoding for the Mandelbrot iteration core
package mbt_pkg;
   localparam int DEF_WIDTH    = 32;
   localparam int DEF_FRAC     = 28;
   localparam int DEF_MAX_ITER = 127;
   localparam logic [2*DEF_WIDTH:0] ESCAPE_R2 = (2*DEF_WIDTH+1)'(4) << (2*DEF_FRAC);
   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/mbt_csq.sv
// mbt_csq: combinational complex square of z with exact |z|^2 > 4.0 escape detect
module mbt_csq
   import mbt_pkg::*;
#(
   parameter int                 WIDTH  = DEF_WIDTH,
   parameter logic [2*WIDTH:0]   R2_LIM = ESCAPE_R2
) (
   input  logic signed [WIDTH-1:0]   z_re,
   input  logic signed [WIDTH-1:0]   z_im,
   output logic signed [2*WIDTH-1:0] zr2,
   output logic signed [2*WIDTH-1:0] zi2,
   output logic signed [2*WIDTH-1:0] zri,
   output logic                      esc
);
   logic signed [2*WIDTH:0] r2;
   always_comb begin
      zr2 = z_re * z_re;
      zi2 = z_im * z_im;
      zri = z_re * z_im;
      r2  = (2*WIDTH+1)'(zr2) + (2*WIDTH+1)'(zi2);
      esc = $unsigned(r2) > R2_LIM;
   end
endmodule

// File: rtl/mbt_iter_core.sv
// mbt_iter_core: one-iteration-per-clock escape-time engine with valid/ack result handshake.
// Define MBT_ITER_STATS_EN to add the stat_points/stat_iters counters.
module mbt_iter_core
   import mbt_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int FRAC     = DEF_FRAC,
   parameter int MAX_ITER = DEF_MAX_ITER
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] c_re,
   input  logic signed [WIDTH-1:0] c_im,
   input  logic                    ack,
   output logic                    ready,
   output logic                    valid,
   output logic [6:0]              d_out
`ifdef MBT_ITER_STATS_EN
   ,
   output logic [31:0]             stat_points,
   output logic [31:0]             stat_iters
`endif
);
   state_t state_q, state_d;
   logic signed [WIDTH-1:0] c_re_q, c_re_d, c_im_q, c_im_d;
   logic signed [WIDTH-1:0] z_re_q, z_re_d, z_im_q, z_im_d;
   logic [6:0] cnt_q, cnt_d, d_out_q, d_out_d;
   logic signed [2*WIDTH-1:0] zr2, zi2, zri;
   logic esc;

   mbt_csq #(
      .WIDTH  (WIDTH),
      .R2_LIM ((2*WIDTH+1)'(4) << (2*FRAC))
   ) u_csq (
      .z_re (z_re_q),
      .z_im (z_im_q),
      .zr2  (zr2),
      .zi2  (zi2),
      .zri  (zri),
      .esc  (esc)
   );

   always_comb begin
      state_d = state_q;
      c_re_d  = c_re_q;
      c_im_d  = c_im_q;
      z_re_d  = z_re_q;
      z_im_d  = z_im_q;
      cnt_d   = cnt_q;
      d_out_d = d_out_q;
      case (state_q)
         IDLE: if (start) begin
            c_re_d  = c_re;
            c_im_d  = c_im;
            z_re_d  = '0;
            z_im_d  = '0;
            cnt_d   = '0;
            state_d = ITER;
         end
         ITER: if (esc) begin
            d_out_d = cnt_q;
            state_d = DONE;
         end else if (cnt_q == 7'(MAX_ITER)) begin
            d_out_d = 7'(MAX_ITER);
            state_d = DONE;
         end else begin
            // 2*zre*zim folds into the shift by FRAC-1
            z_re_d = WIDTH'((zr2 - zi2) >>> FRAC) + c_re_q;
            z_im_d = WIDTH'(zri >>> (FRAC - 1)) + c_im_q;
            cnt_d  = cnt_q + 7'd1;
         end
         DONE: if (ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         c_re_q  <= '0;
         c_im_q  <= '0;
         z_re_q  <= '0;
         z_im_q  <= '0;
         cnt_q   <= '0;
         d_out_q <= '0;
      end else begin
         state_q <= state_d;
         c_re_q  <= c_re_d;
         c_im_q  <= c_im_d;
         z_re_q  <= z_re_d;
         z_im_q  <= z_im_d;
         cnt_q   <= cnt_d;
         d_out_q <= d_out_d;
      end
   end

   assign ready = state_q == IDLE;
   assign valid = state_q == DONE;
   assign d_out = d_out_q;

`ifdef MBT_ITER_STATS_EN
   logic [31:0] stat_points_q, stat_points_d, stat_iters_q, stat_iters_d;
   always_comb begin
      stat_points_d = stat_points_q + 32'(state_q == DONE && ack);
      stat_iters_d  = stat_iters_q + 32'(state_q == ITER);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_points_q <= '0;
         stat_iters_q  <= '0;
      end else begin
         stat_points_q <= stat_points_d;
         stat_iters_q  <= stat_iters_d;
      end
   end
   assign stat_points = stat_points_q;
   assign stat_iters  = stat_iters_q;
`endif
endmodule

// File: tb/tb_mbt_iter_core.sv
// tb_mbt_iter_core: directed and random checks of mbt_iter_core against an integer escape-time model
module tb_mbt_iter_core;
   logic clk = 0, rst = 0, start = 0, ack = 0;
   logic [31:0] c_re = 0, c_im = 0;
   logic ready, valid;
   logic [6:0] d_out;
   int total = 0, bad = 0;
`ifdef MBT_ITER_STATS_EN
   logic [31:0] stat_points, stat_iters;
`endif

   localparam int ONE  = 268435456;
   localparam int P15  = 402653184;
   localparam int M2   = -536870912;
   localparam int P19  = 510027366;

   always #5 clk = ~clk;

   mbt_iter_core dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .c_re  (c_re),
      .c_im  (c_im),
      .ack   (ack),
      .ready (ready),
      .valid (valid),
      .d_out (d_out)
`ifdef MBT_ITER_STATS_EN
      ,
      .stat_points (stat_points),
      .stat_iters  (stat_iters)
`endif
   );

   function automatic int ref_count(input int cr, input int ci);
      longint zr, zi, lim;
      int tr, ti;
      zr  = 0;
      zi  = 0;
      lim = longint'(4) << 56;
      for (int n = 0; n <= 127; n++) begin
         if (zr * zr + zi * zi > lim) return n;
         if (n == 127) return 127;
         tr = int'((zr * zr - zi * zi) >>> 28) + cr;
         ti = int'((2 * zr * zi) >>> 28) + ci;
         zr = tr;
         zi = ti;
      end
      return 127;
   endfunction

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic launch(input int cr, input int ci);
      @(negedge clk);
      c_re  = cr;
      c_im  = ci;
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!valid && lat < 200);
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack = 1;
      @(posedge clk);
      #1;
      ack = 0;
      chk("ack_valid", valid, 0);
      chk("ack_ready", ready, 1);
   endtask

   task automatic run_point(input string tag, input int cr, input int ci, input int exp);
      int lat;
      launch(cr, ci);
      wait_valid(lat);
      chk({tag, "_lat"}, lat, exp + 1);
      chk({tag, "_dout"}, d_out, exp);
      chk({tag, "_busy"}, ready, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      chk({tag, "_hold"}, valid, 1);
      do_ack();
   endtask

   initial begin
      int lat, cr, ci;
      repeat (2) @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_valid", valid, 0);
      chk("rst_dout", d_out, 0);
      @(negedge clk);
      rst = 1;
      // origin never escapes; result held without ack
      launch(0, 0);
      wait_valid(lat);
      chk("zero_lat", lat, 128);
      chk("zero_dout", d_out, 127);
      repeat (10) @(posedge clk);
      #1;
      chk("zero_hold_valid", valid, 1);
      chk("zero_hold_dout", d_out, 127);
      do_ack();
      run_point("c15", P15, 0, 2);
      run_point("cm2", M2, 0, 127);
      run_point("ci1", 0, ONE, 127);
      run_point("c19", P19, P19, 1);
      // start and ack during ITER are ignored
      launch(0, 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      start = 1;
      ack   = 1;
      c_re  = P19;
      c_im  = P19;
      @(negedge clk);
      start = 0;
      ack   = 0;
      wait_valid(lat);
      chk("ign_lat", lat, 122);
      chk("ign_dout", d_out, 127);
      @(negedge clk);
      start = 1;
      ack   = 1;
      c_re  = P15;
      c_im  = 0;
      @(posedge clk);
      #1;
      chk("both_valid", valid, 0);
      chk("both_ready", ready, 1);
      @(negedge clk);
      start = 0;
      ack   = 0;
      @(posedge clk);
      #1;
      chk("both_nocap", ready, 1);
      // async reset in the 50th ITER cycle
      launch(0, 0);
      repeat (49) @(posedge clk);
      #2;
      rst = 0;
      #1;
      chk("arst_valid", valid, 0);
      chk("arst_ready", ready, 1);
      chk("arst_dout", d_out, 0);
`ifdef MBT_ITER_STATS_EN
      chk("arst_pts", stat_points, 0);
      chk("arst_its", stat_iters, 0);
`endif
      @(negedge clk);
      rst = 1;
      run_point("post", P15, 0, 2);
`ifdef MBT_ITER_STATS_EN
      chk("post_pts", stat_points, 1);
      chk("post_its", stat_iters, 3);
`endif
      for (int i = 0; i < 30; i++) begin
         cr = (i % 2) ? (int'($urandom) >>> 3) : (int'($urandom) >>> 2);
         ci = (i % 3) ? (int'($urandom) >>> 3) : (int'($urandom) >>> 2);
         run_point("rnd", cr, ci, ref_count(cr, ci));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
